// File: rtl/wishbone_ram_slave_if.sv
// Wishbone B4 classic-cycle bus signals between one master and the RAM responder.
interface wishbone_ram_slave_if;
    logic [31:0] wb_addr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic        wb_stb;
    logic        wb_cyc;
    logic        wb_ack;
    logic        wb_err;

    modport master (
        output wb_addr, wb_dat_i, wb_we, wb_sel, wb_stb, wb_cyc,
        input  wb_dat_o, wb_ack, wb_err
    );

    modport slave (
        input  wb_addr, wb_dat_i, wb_we, wb_sel, wb_stb, wb_cyc,
        output wb_dat_o, wb_ack, wb_err
    );
endinterface

// File: rtl/wishbone_ram_slave.sv
// Word-organised RAM behind a Wishbone classic-cycle slave port, with a decoded address
// window, programmable wait states and one-cycle ack/err termination.
module wishbone_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone_ram_slave_if.slave  wb,
    output logic                 busy
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam logic [3:0]  WaitLoad = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam logic [32:0] WinLo    = {1'b0, BASE_ADDR};
    localparam logic [32:0] WinHi    = WinLo + 33'(DEPTH_WORDS) * 33'd4;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q;
    logic          hit_q, we_q;
    logic [3:0]    sel_q;
    logic [31:0]   dat_q;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          hit;
    logic [31:0]   offset;
    logic          resp_hit;

    assign req    = wb.wb_cyc && wb.wb_stb;
    // 33-bit compare so a window touching the top of the address space cannot wrap.
    assign hit    = ({1'b0, wb.wb_addr} >= WinLo) && ({1'b0, wb.wb_addr} < WinHi);
    assign offset = wb.wb_addr - BASE_ADDR;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end
                end
            end
            StWait: begin
                if (!wb.wb_cyc) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            hit_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            dat_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && req) begin
                idx_q <= AW'(offset >> 2);
                hit_q <= hit;
                we_q  <= wb.wb_we;
                sel_q <= wb.wb_sel;
                dat_q <= wb.wb_dat_i;
            end
        end
    end

    assign resp_hit = (state_q == StResp) && hit_q;

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (resp_hit && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= dat_q[8*b +: 8];
                end
            end
        end
    end

    assign wb.wb_ack   = resp_hit;
    assign wb.wb_err   = (state_q == StResp) && !hit_q;
    assign wb.wb_dat_o = (resp_hit && !we_q) ? mem[idx_q] : 32'd0;
    assign busy        = (state_q != StIdle);
endmodule
